// File: rtl/pri_rv32.sv
`default_nettype none
// ============================================================================
// Module   : pri_rv32
// Brief    : Single-cycle RV32I-subset core with instruction ROM and an
//            8-bit memory-mapped output register.
// Revision : 1.0 - initial release
// ============================================================================
module pri_rv32 #(
  parameter int unsigned               ROM_DEPTH = 16,
  parameter logic [31:0]               OUT_ADDR  = 32'h0000_0100,
  parameter logic [32*ROM_DEPTH-1:0]   ROM_INIT  = {{(ROM_DEPTH-3){32'h0000_0013}},
                                                    32'hFF9F_F06F,
                                                    32'h1010_2023,
                                                    32'h0010_8093}
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       enable,
  output logic      [7:0] out
);

  localparam int unsigned AW = $clog2(ROM_DEPTH);

  localparam logic [6:0] c_OP_IMM = 7'b0010011;
  localparam logic [6:0] c_OP     = 7'b0110011;
  localparam logic [6:0] c_LUI    = 7'b0110111;
  localparam logic [6:0] c_JAL    = 7'b1101111;
  localparam logic [6:0] c_BRANCH = 7'b1100011;
  localparam logic [6:0] c_STORE  = 7'b0100011;

  logic [31:0] r_pc;
  logic [31:0] r_regs [32];
  logic [7:0]  r_out;

  logic [AW-1:0] w_idx;
  logic [31:0]   w_instr;
  logic [6:0]    w_opc;
  logic [2:0]    w_f3;
  logic [6:0]    w_f7;
  logic [4:0]    w_rd, w_rs1, w_rs2;
  logic [31:0]   w_a, w_b;
  logic [31:0]   w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
  logic [31:0]   w_next_pc, w_wd, w_ea;
  logic          w_we, w_st;

  // PC[1:0] ignored; upper PC bits wrap modulo ROM size
  assign w_idx   = r_pc[AW+1:2];
  assign w_instr = ROM_INIT[{w_idx, 5'd0} +: 32];

  assign w_opc = w_instr[6:0];
  assign w_rd  = w_instr[11:7];
  assign w_f3  = w_instr[14:12];
  assign w_rs1 = w_instr[19:15];
  assign w_rs2 = w_instr[24:20];
  assign w_f7  = w_instr[31:25];

  assign w_a = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
  assign w_b = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];

  assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                    w_instr[11:8], 1'b0};
  assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                    w_instr[30:21], 1'b0};
  assign w_imm_u = {w_instr[31:12], 12'd0};
  assign w_ea    = w_a + w_imm_s;

  always_comb begin
    w_next_pc = r_pc + 32'd4;
    w_we      = 1'b0;
    w_wd      = 32'd0;
    w_st      = 1'b0;
    case (w_opc)
      c_OP_IMM: begin
        w_we = 1'b1;
        case (w_f3)
          3'b000:  w_wd = w_a + w_imm_i;
          3'b010:  w_wd = {31'd0, $signed(w_a) < $signed(w_imm_i)};
          3'b100:  w_wd = w_a ^ w_imm_i;
          3'b110:  w_wd = w_a | w_imm_i;
          3'b111:  w_wd = w_a & w_imm_i;
          default: w_we = 1'b0;
        endcase
      end
      c_OP: begin
        w_we = 1'b1;
        if (w_f7 == 7'b0000000) begin
          case (w_f3)
            3'b000:  w_wd = w_a + w_b;
            3'b010:  w_wd = {31'd0, $signed(w_a) < $signed(w_b)};
            3'b100:  w_wd = w_a ^ w_b;
            3'b110:  w_wd = w_a | w_b;
            3'b111:  w_wd = w_a & w_b;
            default: w_we = 1'b0;
          endcase
        end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
          w_wd = w_a - w_b;
        end else begin
          w_we = 1'b0;
        end
      end
      c_LUI: begin
        w_we = 1'b1;
        w_wd = w_imm_u;
      end
      c_JAL: begin
        w_we      = 1'b1;
        w_wd      = r_pc + 32'd4;
        w_next_pc = r_pc + w_imm_j;
      end
      c_BRANCH: begin
        if ((w_f3 == 3'b000 && w_a == w_b) || (w_f3 == 3'b001 && w_a != w_b))
          w_next_pc = r_pc + w_imm_b;
      end
      c_STORE: begin
        w_st = (w_f3 == 3'b010) && (w_ea == OUT_ADDR);
      end
      default: ;
    endcase
    if (w_rd == 5'd0)
      w_we = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc  <= 32'd0;
      r_out <= 8'd0;
      for (int k = 0; k < 32; k++)
        r_regs[k] <= 32'd0;
    end else if (enable) begin
      r_pc <= w_next_pc;
      if (w_we)
        r_regs[w_rd] <= w_wd;
      if (w_st)
        r_out <= w_b[7:0];
    end
  end

  assign out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_pri_rv32.sv
`default_nettype none
// Directed testbench for pri_rv32: default counter program plus an
// alternate ROM image exercising LUI/ADDI/SUB/BNE/SW.
module tb_pri_rv32;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] out;
  logic [7:0] out_isa;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [32*16-1:0] c_ISA_ROM = {{10{32'h0000_0013}},
                                            32'h1030_2023,
                                            32'h0550_0213,
                                            32'h0001_9463,
                                            32'h4020_01B3,
                                            32'hFFF1_0113,
                                            32'h0000_1137};

  always #10 clk = ~clk;

  pri_rv32 dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .out    (out)
  );

  pri_rv32 #(.ROM_INIT(c_ISA_ROM)) dut_isa (
    .clk    (clk),
    .reset  (reset),
    .enable (1'b1),
    .out    (out_isa)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance n rising edges, then sample just after the last one
  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b1;
    #5;
    chk("out_in_reset", {24'd0, out}, 32'h0);
    #10 reset = 1'b1;

    run(2);  chk("out_edge2", {24'd0, out}, 32'd1);
    run(3);  chk("out_edge5", {24'd0, out}, 32'd2);
    run(3);  chk("out_edge8", {24'd0, out}, 32'd3);
    chk("x1_edge8", dut.r_regs[1], 32'd3);
    run(41); chk("out_edge49", {24'd0, out}, 32'd16);
    run(1);  chk("out_edge50", {24'd0, out}, 32'd17);

    // fresh start for the stall sequence
    reset = 1'b0;
    #2 reset = 1'b1;
    run(11);
    chk("out_pre_stall", {24'd0, out}, 32'd4);
    chk("pc_pre_stall", dut.r_pc, 32'd8);
    enable = 1'b0;
    run(10);
    chk("out_stalled", {24'd0, out}, 32'd4);
    chk("pc_stalled", dut.r_pc, 32'd8);
    chk("x1_stalled", dut.r_regs[1], 32'd4);
    enable = 1'b1;
    run(2);  chk("out_resume2", {24'd0, out}, 32'd4);
    run(1);  chk("out_resume3", {24'd0, out}, 32'd5);
    run(6);  chk("out_seven", {24'd0, out}, 32'd7);

    // asynchronous reset between edges
    #5 reset = 1'b0;
    #1;
    chk("out_async_rst", {24'd0, out}, 32'd0);
    chk("pc_async_rst", dut.r_pc, 32'd0);
    chk("x1_async_rst", dut.r_regs[1], 32'd0);
    #1 reset = 1'b1;
    run(2);  chk("out_restart", {24'd0, out}, 32'd1);

    run(764); chk("out_edge766", {24'd0, out}, 32'hFF);
    run(1);   chk("out_wrap", {24'd0, out}, 32'h00);
    chk("x1_wrap", dut.r_regs[1], 32'h100);

    chk("isa_out", {24'd0, out_isa}, 32'h01);
    chk("isa_x2", dut_isa.r_regs[2], 32'h0000_0FFF);
    chk("isa_x3", dut_isa.r_regs[3], 32'hFFFF_F001);
    chk("isa_x4", dut_isa.r_regs[4], 32'h0);
    chk("isa_x0", dut_isa.r_regs[0], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
